sipo_frame_ctrl: RTL and testbench

//  Sequences serial-to-parallel capture of fixed-length WIDTH-bit words.

---
 rtl/sipo_frame_ctrl_if.sv | 36 +++
 rtl/sipo_frame_ctrl.sv | 109 ++++++++++
 tb/tb_sipo_frame_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/sipo_frame_ctrl_if.sv
// Serial-in / parallel-out word bus between a bit source, the frame controller and a word sink.
// The slave modport is the controller's view; the master modport is the source/sink side.
interface sipo_frame_ctrl_if #(
    parameter int WIDTH = 4
);
    logic             serial_in;
    logic             start;
    logic [WIDTH-1:0] parallel_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;
    logic             ovr_clr;

    modport slave (
        input  serial_in,
        input  start,
        input  out_ready,
        input  ovr_clr,
        output parallel_out,
        output out_valid,
        output busy,
        output overrun
    );

    modport master (
        output serial_in,
        output start,
        output out_ready,
        output ovr_clr,
        input  parallel_out,
        input  out_valid,
        input  busy,
        input  overrun
    );
endinterface

// File: rtl/sipo_frame_ctrl.sv
// Captures MSB-first serial words of WIDTH bits and offers each one on a valid/ready output.
// A word that completes while the previous one is still unconsumed is dropped and flagged.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    sipo_frame_ctrl_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    // Only WIDTH-1 bits are kept; the last bit is merged straight into the candidate word.
    logic [WIDTH-2:0]   r_sreg;
    logic [WIDTH-1:0]   w_word;
    logic               w_complete;
    logic               w_accept;
    logic [WIDTH-1:0]   r_parallel_out;
    logic               r_out_valid;
    logic               r_overrun;

    assign w_word     = {r_sreg, bus.serial_in};
    assign w_complete = (r_state == ST_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
    assign w_accept   = r_out_valid && bus.out_ready;

    // State, bit counter and shift register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_sreg  <= {(WIDTH-1){1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (r_state == ST_SHIFT) begin
                r_sreg <= w_word[WIDTH-2:0];
            end else begin
                r_sreg <= r_sreg;
            end
        end
    end

    // Next-state and counter logic
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_SHIFT;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_complete) begin
                    w_state_nxt = bus.start ? ST_SHIFT : ST_IDLE;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output word handshake and sticky overrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parallel_out <= {WIDTH{1'b0}};
            r_out_valid    <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            if (w_complete && (!r_out_valid || w_accept)) begin
                r_parallel_out <= w_word;
                r_out_valid    <= 1'b1;
            end else if (w_accept) begin
                r_out_valid    <= 1'b0;
            end else begin
                r_out_valid    <= r_out_valid;
            end
            // A drop on the same edge as a clear must leave the flag set
            if (w_complete && r_out_valid && !bus.out_ready) begin
                r_overrun <= 1'b1;
            end else if (bus.ovr_clr) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
        end
    end

    assign bus.parallel_out = r_parallel_out;
    assign bus.out_valid    = r_out_valid;
    assign bus.overrun      = r_overrun;
    assign bus.busy         = (r_state == ST_SHIFT);
endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed self-checking bench for sipo_frame_ctrl with WIDTH = 4.
module tb_sipo_frame_ctrl;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    sipo_frame_ctrl_if #(.WIDTH(4)) bus ();

    sipo_frame_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus.serial_in = b;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
    endtask

    initial begin
        logic [7:0] pat;
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b0;
        bus.serial_in = 1'b0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;
        bus.ovr_clr   = 1'b0;
        #12;
        reset = 1'b1;
        tick();
        check("rst_po",    32'(bus.parallel_out), 32'h0);
        check("rst_valid", 32'(bus.out_valid),    32'h0);
        check("rst_busy",  32'(bus.busy),         32'h0);
        check("rst_ovr",   32'(bus.overrun),      32'h0);

        // Single word 1,0,1,0
        bus.start = 1'b1;
        tick();
        check("t2_busy_n", 32'(bus.busy), 32'h1);
        bus.start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("t2_busy_n3", 32'(bus.busy), 32'h1);
        check("t2_valid_n3", 32'(bus.out_valid), 32'h0);
        send_bit(1'b0);
        check("t2_po",    32'(bus.parallel_out), 32'ha);
        check("t2_valid", 32'(bus.out_valid),    32'h1);
        check("t2_busy",  32'(bus.busy),         32'h0);

        // Stall then consume
        for (int i = 0; i < 10; i++) begin
            bus.serial_in = i[0];
            tick();
            check("t3_po_hold",    32'(bus.parallel_out), 32'ha);
            check("t3_valid_hold", 32'(bus.out_valid),    32'h1);
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t3_valid_acc", 32'(bus.out_valid),    32'h0);
        check("t3_po_acc",    32'(bus.parallel_out), 32'ha);

        // Back-to-back words, consumer ready
        pat = 8'b1100_0111;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i == 4) begin
                check("t4_w0",    32'(bus.parallel_out), 32'hc);
                check("t4_v0",    32'(bus.out_valid),    32'h1);
                check("t4_busy0", 32'(bus.busy),         32'h1);
            end
        end
        check("t4_w1",   32'(bus.parallel_out), 32'h7);
        check("t4_v1",   32'(bus.out_valid),    32'h1);
        check("t4_ovr",  32'(bus.overrun),      32'h0);
        bus.start = 1'b0;
        bus.out_ready = 1'b0;
        do_reset();

        // Same stimulus with consumer stalled
        bus.start = 1'b1;
        tick();
        for (int i = 7; i >= 0; i--) begin
            send_bit(pat[i]);
            if (i == 4) begin
                check("t5_w0",   32'(bus.parallel_out), 32'hc);
                check("t5_ovr0", 32'(bus.overrun),      32'h0);
            end
        end
        check("t5_po",    32'(bus.parallel_out), 32'hc);
        check("t5_valid", 32'(bus.out_valid),    32'h1);
        check("t5_ovr",   32'(bus.overrun),      32'h1);
        bus.start = 1'b0;
        tick();
        check("t5_ovr_sticky", 32'(bus.overrun), 32'h1);
        bus.ovr_clr = 1'b1;
        tick();
        bus.ovr_clr = 1'b0;
        check("t5_ovr_clr", 32'(bus.overrun), 32'h0);

        // Asynchronous reset while shifting with a word pending
        check("t1_busy_pre", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        #1;
        check("t1_po",    32'(bus.parallel_out), 32'h0);
        check("t1_valid", 32'(bus.out_valid),    32'h0);
        check("t1_busy",  32'(bus.busy),         32'h0);
        check("t1_ovr",   32'(bus.overrun),      32'h0);
        #2;
        reset = 1'b1;
        tick();
        check("t1_idle", 32'(bus.busy), 32'h0);

        // Reset after a partial word, then a clean word 0,1,1,0
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        do_reset();
        tick();
        tick();
        check("t6_busy_idle",  32'(bus.busy),      32'h0);
        check("t6_valid_idle", 32'(bus.out_valid), 32'h0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("t6_po",    32'(bus.parallel_out), 32'h6);
        check("t6_valid", 32'(bus.out_valid),    32'h1);

        // Drop and clear on the same edge: set wins
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        bus.ovr_clr = 1'b1;
        send_bit(1'b1);
        bus.ovr_clr = 1'b0;
        check("t7_ovr_set_wins", 32'(bus.overrun),      32'h1);
        check("t7_po_kept",      32'(bus.parallel_out), 32'h6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
